fir_out_decimator: RTL and testbench
====================================

# fir_out_decimator

Output stage placed directly after `fir_filter`. It takes the filter's 18-bit signed result, keeps one of every DECIM valid samples, and rounds and saturates the kept sample to OUT_W bits. Results go into a small FIFO with a valid/ready output, so the filter can run every clock while the downstream consumer (DAC or serializer) stalls.

## Interface
- IN_W, 18: input width; matches `fir_filter` `data_out`; two's complement.
- OUT_W, 8: output width; two's complement.
- SHIFT, 10: right-shift applied after rounding; 1 ≤ SHIFT < IN_W.
- DECIM, 4: decimation factor; ≥ 1; DECIM=1 keeps every sample.
- DEPTH, 4: FIFO depth; power of two, ≥ 2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset; clears every register.
- in_data  in  IN_W  filter output sample, signed.
- in_valid  in  1  in_data is valid this cycle.
- out_data  out  OUT_W  FIFO head, signed; reset 0.
- out_valid  out  1  FIFO non-empty; reset 0.
- out_ready  in  1  consumer accepts out_data when out_valid & out_ready.
- fill_level  out  log2(DEPTH)+1  current FIFO occupancy; reset 0.
- sat_flag  out  1  sticky; set when any kept sample saturates; cleared only by reset; reset 0.
- drop  out  1  one-cycle pulse when a processed sample is lost because the FIFO is full; reset 0.

## Operation
- Phase counter, range 0..DECIM-1, reset 0.
  - Advances only on in_valid and wraps DECIM-1 → 0.
  - A sample is kept when in_valid=1 and phase==0.
- Stage 1, on a kept sample: r = (sign-extended in_data, IN_W+1 bits) + 2^(SHIFT-1), then arithmetic shift right by SHIFT. This is round-half-up; −1.5 rounds to −1.
- Stage 2, saturation:
  - r > 2^(OUT_W-1)−1 → 2^(OUT_W-1)−1, and sat_flag is set.
  - r < −2^(OUT_W-1) → −2^(OUT_W-1), and sat_flag is set.
  - Otherwise r[OUT_W-1:0].
  - The result is pushed into the FIFO in the same cycle.
- Both stages carry a valid bit. Bubbles propagate. Stages never stall.
- FIFO: circular buffer with read/write pointers one bit wider than the address.
  - Push with not full: store the value.
  - Push with full and no pop in the same cycle: discard the value and pulse drop.
  - Push and pop in the same cycle while full: both succeed; level stays DEPTH; no drop.
  - Push and pop in the same cycle while empty: the new value enters. There is no bypass, so out_valid rises the next cycle.
  - Pop with out_valid=0: ignored.
- out_data is always the FIFO head. It is stable while out_valid=1 and out_ready=0.
- Reset asserted mid-operation: phase, pipeline valids, pointers, fill_level, sat_flag and drop go to 0 immediately. In-flight samples are discarded.

## Timing
- Kept sample sampled at edge E0 → stage 1 registered at E0 → FIFO write at E1.
- With the FIFO empty, out_valid=1 and the new out_data are visible after E1: 2-cycle latency.
- Throughput: one kept sample per clock when DECIM=1.
- fill_level and out_valid update on the same edge as the push or pop.
- drop is asserted in the cycle following the rejected write edge, for exactly one cycle.
- Phase wrap is visible on the edge carrying the DECIM-th valid sample.
- in_valid=0 cycles do not advance the phase.
- Reset release: the first valid sample after rst goes high is kept (phase 0).

## Test plan
- Rounding (DECIM=1, out_ready=1):
  - in_data 1536 → out 2.
  - 1535 → 1.
  - −1536 → −1.
  - −131072 → −128 with sat_flag=0.
  - Each result has out_valid exactly 2 edges after input.
- Saturation: in_data 131071 → out 127 and sat_flag=1. Then send 0 → out 0 and sat_flag remains 1.
- Decimation (DECIM=4): 12 consecutive valid inputs k·1024, k=0..11 → outputs exactly 0, 4, 8.
  - Insert in_valid=0 gaps; the same three outputs appear.
- Backpressure (DECIM=1, out_ready=0): 6 valid inputs 1024..6144.
  - fill_level reaches 4; drop pulses twice.
  - Raising out_ready drains 1, 2, 3, 4 in order, then out_valid=0.
- Full with simultaneous push and pop: keep FIFO full and out_ready=1 while streaming. Result: no drop, fill_level stays 4, output order preserved.
- Reset mid-stream: assert rst low between clock edges with fill_level=3 and the pipeline busy.
  - All outputs go to 0 without waiting for a clock edge.
  - After release, the first input 2048 → out 2.

Source files
------------

// File: rtl/fir_out_decimator_if.sv
// Stream bundle between fir_out_decimator and its surroundings: sample input,
// valid/ready output and status flags.
interface fir_out_decimator_if #(
  parameter int IN_W  = 18,
  parameter int OUT_W = 8,
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic signed [IN_W-1:0]  in_data;
  logic                    in_valid;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [LW-1:0]           fill_level;
  logic                    sat_flag;
  logic                    drop;

  modport master (
    output in_data, in_valid, out_ready,
    input  out_data, out_valid, fill_level, sat_flag, drop
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output out_data, out_valid, fill_level, sat_flag, drop
  );
endinterface

// File: rtl/fir_out_decimator.sv
// Keeps one of every DECIM filter samples, rounds/saturates it to OUT_W bits
// and queues it in a small FIFO so the consumer can stall independently.
module fir_out_decimator #(
  parameter int IN_W  = 18,
  parameter int OUT_W = 8,
  parameter int SHIFT = 10,
  parameter int DECIM = 4,
  parameter int DEPTH = 4
) (
  input logic              clk,
  input logic              rst,
  fir_out_decimator_if.slave bus
);
  localparam int R_W = IN_W + 1 - SHIFT;
  localparam int CW  = ((R_W > OUT_W) ? R_W : OUT_W) + 1;
  localparam int PW  = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int AW  = $clog2(DEPTH);

  localparam logic [IN_W:0]          ROUND_U = (IN_W + 1)'(1) << (SHIFT - 1);
  localparam logic signed [CW-1:0]   SAT_MAX = CW'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [CW-1:0]   SAT_MIN = CW'(-(2 ** (OUT_W - 1)));
  localparam logic [AW:0]            FULL_LEVEL = (AW + 1)'(DEPTH);

  logic [PW-1:0]          phase_reg;
  logic                   s1_valid_reg;
  logic signed [R_W-1:0]  s1_data_reg;
  logic [AW:0]            wr_ptr_reg;
  logic [AW:0]            rd_ptr_reg;
  logic                   sat_flag_reg;
  logic                   drop_reg;
  logic [OUT_W-1:0]       mem [DEPTH];

  logic                   keep;
  logic signed [IN_W:0]   in_ext;
  logic signed [CW-1:0]   r_ext;
  logic                   over;
  logic                   under;
  logic [OUT_W-1:0]       sat_data;
  logic [AW:0]            count;
  logic                   full;
  logic                   empty;
  logic                   push;
  logic                   pop;
  logic                   wr_en;

  assign keep   = bus.in_valid && (phase_reg == '0);
  assign in_ext = {bus.in_data[IN_W-1], bus.in_data};

  // Saturation is judged on the full-precision rounded value, widened by one bit.
  assign r_ext = {{(CW - R_W){s1_data_reg[R_W-1]}}, s1_data_reg};
  assign over  = r_ext > SAT_MAX;
  assign under = r_ext < SAT_MIN;

  always_comb begin
    sat_data = r_ext[OUT_W-1:0];
    if (over)
      sat_data = {1'b0, {(OUT_W - 1){1'b1}}};
    else if (under)
      sat_data = {1'b1, {(OUT_W - 1){1'b0}}};
  end

  assign count = wr_ptr_reg - rd_ptr_reg;
  assign full  = (count == FULL_LEVEL);
  assign empty = (count == '0);
  assign push  = s1_valid_reg;
  assign pop   = bus.out_ready && !empty;
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_reg    <= '0;
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      sat_flag_reg <= 1'b0;
      drop_reg     <= 1'b0;
    end else begin
      if (bus.in_valid)
        phase_reg <= (phase_reg == PW'(DECIM - 1)) ? '0 : phase_reg + 1'b1;
      s1_valid_reg <= keep;
      if (keep)
        s1_data_reg <= R_W'((in_ext + $signed(ROUND_U)) >>> SHIFT);
      if (push && (over || under))
        sat_flag_reg <= 1'b1;
      if (wr_en)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      drop_reg <= push && full && !pop;
    end
  end

  // Storage carries no reset so it maps onto plain RAM; the head is masked while empty.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr_reg[AW-1:0]] <= sat_data;
  end

  assign bus.out_data   = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];
  assign bus.out_valid  = !empty;
  assign bus.fill_level = count;
  assign bus.sat_flag   = sat_flag_reg;
  assign bus.drop       = drop_reg;
endmodule

// File: tb/tb_fir_out_decimator.sv
// Directed bench: DECIM=1 instance for rounding/FIFO/reset, DECIM=4 instance for decimation.
module tb_fir_out_decimator;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fir_out_decimator_if #(.IN_W(18), .OUT_W(8), .DEPTH(4)) if1 ();
  fir_out_decimator_if #(.IN_W(18), .OUT_W(8), .DEPTH(4)) if4 ();

  fir_out_decimator #(.IN_W(18), .OUT_W(8), .SHIFT(10), .DECIM(1), .DEPTH(4)) dut1 (
    .clk(clk), .rst(rst), .bus(if1.slave));
  fir_out_decimator #(.IN_W(18), .OUT_W(8), .SHIFT(10), .DECIM(4), .DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .bus(if4.slave));

  typedef struct {
    int din;
    int dout;
    int sat;
  } vec_t;

  vec_t vecs[8];
  int   checks = 0;
  int   fails  = 0;
  int   q1[$];
  int   q4[$];

  always @(posedge clk) begin
    if (if1.out_valid && if1.out_ready) q1.push_back(int'(if1.out_data));
    if (if4.out_valid && if4.out_ready) q4.push_back(int'(if4.out_data));
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic v, input int d);
    if1.in_valid = v;
    if1.in_data  = d[17:0];
  endtask

  task automatic drive4(input logic v, input int d);
    if4.in_valid = v;
    if4.in_data  = d[17:0];
  endtask

  task automatic check_queue(input string name, input int exp_n, input int step, ref int q[$]);
    check({name, "_count"}, q.size(), exp_n);
    for (int i = 0; i < exp_n; i++)
      check(name, (i < q.size()) ? q[i] : -999, step * i + ((step == 4) ? 0 : 1));
  endtask

  initial begin
    int drops;
    int max_fill;

    vecs[0] = '{1536, 2, 0};
    vecs[1] = '{1535, 1, 0};
    vecs[2] = '{-1536, -1, 0};
    vecs[3] = '{-131072, -128, 0};
    vecs[4] = '{511, 0, 0};
    vecs[5] = '{-513, -1, 0};
    vecs[6] = '{131071, 127, 1};
    vecs[7] = '{0, 0, 1};

    drive1(1'b0, 0);
    drive4(1'b0, 0);
    if1.out_ready = 1'b1;
    if4.out_ready = 1'b1;

    repeat (2) tick();
    check("rst_out_valid", int'(if1.out_valid), 0);
    check("rst_out_data", int'(if1.out_data), 0);
    check("rst_fill", int'(if1.fill_level), 0);
    check("rst_sat", int'(if1.sat_flag), 0);
    check("rst_drop", int'(if1.drop), 0);
    rst = 1'b1;

    // Rounding and saturation, each with exact two-edge latency.
    for (int i = 0; i < 8; i++) begin
      drive1(1'b1, vecs[i].din);
      tick();
      drive1(1'b0, 0);
      check("lat_early_valid", int'(if1.out_valid), 0);
      tick();
      check("vec_valid", int'(if1.out_valid), 1);
      check("vec_data", int'(if1.out_data), vecs[i].dout);
      check("vec_sat", int'(if1.sat_flag), vecs[i].sat);
      tick();
      check("vec_drained", int'(if1.out_valid), 0);
    end

    // Decimation, back-to-back then with gaps carrying junk data.
    q4.delete();
    for (int k = 0; k < 12; k++) begin
      drive4(1'b1, k * 1024);
      tick();
    end
    drive4(1'b0, 0);
    repeat (4) tick();
    check_queue("decim", 3, 4, q4);

    q4.delete();
    for (int k = 0; k < 12; k++) begin
      drive4(1'b1, k * 1024);
      tick();
      if (k % 3 == 1) begin
        drive4(1'b0, 99 * 1024);
        tick();
      end
    end
    drive4(1'b0, 0);
    repeat (4) tick();
    check_queue("decim_gap", 3, 4, q4);

    // Backpressure: six pushes into a depth-4 FIFO.
    if1.out_ready = 1'b0;
    drops = 0;
    max_fill = 0;
    for (int k = 1; k <= 10; k++) begin
      if (k <= 6) drive1(1'b1, k * 1024);
      else drive1(1'b0, 0);
      tick();
      drops += int'(if1.drop);
      if (int'(if1.fill_level) > max_fill) max_fill = int'(if1.fill_level);
    end
    check("bp_drops", drops, 2);
    check("bp_max_fill", max_fill, 4);
    check("bp_fill", int'(if1.fill_level), 4);
    check("bp_head", int'(if1.out_data), 1);
    q1.delete();
    if1.out_ready = 1'b1;
    repeat (6) tick();
    check_queue("bp_drain", 4, 1, q1);
    check("bp_empty", int'(if1.out_valid), 0);

    // Full FIFO with simultaneous push and pop every cycle.
    if1.out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      drive1(1'b1, k * 1024);
      tick();
    end
    drive1(1'b0, 0);
    repeat (2) tick();
    check("full_pre_fill", int'(if1.fill_level), 4);
    q1.delete();
    drops = 0;
    for (int i = 0; i < 8; i++) begin
      drive1(1'b1, (5 + i) * 1024);
      if (i == 1) if1.out_ready = 1'b1;
      tick();
      check("full_fill", int'(if1.fill_level), 4);
      drops += int'(if1.drop);
    end
    drive1(1'b0, 0);
    tick();
    check("full_fill_last", int'(if1.fill_level), 4);
    drops += int'(if1.drop);
    repeat (6) tick();
    check("full_drops", drops, 0);
    check_queue("full_order", 12, 1, q1);

    // Asynchronous reset with three entries queued and one sample in flight.
    if1.out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      drive1(1'b1, k * 1024);
      tick();
    end
    drive1(1'b0, 0);
    check("pre_rst_fill", int'(if1.fill_level), 3);
    check("pre_rst_sat", int'(if1.sat_flag), 1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_out_valid", int'(if1.out_valid), 0);
    check("arst_out_data", int'(if1.out_data), 0);
    check("arst_fill", int'(if1.fill_level), 0);
    check("arst_sat", int'(if1.sat_flag), 0);
    check("arst_drop", int'(if1.drop), 0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    tick();
    tick();
    check("post_rst_idle", int'(if1.out_valid), 0);
    if1.out_ready = 1'b1;
    drive1(1'b1, 2048);
    tick();
    drive1(1'b0, 0);
    check("post_rst_early", int'(if1.out_valid), 0);
    tick();
    check("post_rst_valid", int'(if1.out_valid), 1);
    check("post_rst_data", int'(if1.out_data), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
